// File: rtl/apb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// apb_pkg : shared FSM state type and I2C-bridge register map.  Rev 1.0
// ------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [31:0] APB_ADDR_TX      = 32'h0000_0000;
  localparam logic [31:0] APB_ADDR_RX      = 32'h0000_0004;
  localparam logic [31:0] APB_ADDR_CONFIG  = 32'h0000_0008;
  localparam logic [31:0] APB_ADDR_TIMEOUT = 32'h0000_000C;

endpackage
`default_nettype wire

// File: rtl/apb_master_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// apb_master_if : command/response port plus APB bus of the requester.  Rev 1.0
// ------------------------------------------------------------------------
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_WRITE;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [DATA_W-1:0] CMD_WDATA;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_RDATA;
  logic              RSP_ERR;
  logic              RSP_TIMEOUT;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, PRDATA, PREADY, PSLVERR,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, PRDATA, PREADY, PSLVERR,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RSP_TIMEOUT,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ------------------------------------------------------------------------
// apb_wait_timer : counts ACCESS wait states; TIMEOUT_CYCLES=0 never expires.  Rev 1.0
// ------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // expired flags the last permitted wait cycle, so the abort lands on exactly TIMEOUT_CYCLES
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_never
      assign expired = 1'b0;
    end else begin : g_limit
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      assign expired = (cnt == LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ------------------------------------------------------------------------
// apb_master : single-command APB requester with wait-state timeout.  Rev 1.0
// ------------------------------------------------------------------------
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_master_if.master bus
);

  apb_state_t        state;
  apb_state_t        next_state;
  logic              cmd_ready;
  logic              accept;
  logic              complete;
  logic              abort;
  logic              expired;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= next_state;
  end

  // ready rides on PREADY in ACCESS so a queued command chains straight into SETUP
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.CMD_VALID) next_state = SETUP;
      end
      SETUP: next_state = ACCESS;
      ACCESS: begin
        if (bus.PREADY) begin
          cmd_ready  = 1'b1;
          complete   = 1'b1;
          next_state = bus.CMD_VALID ? SETUP : IDLE;
        end else if (expired) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept = bus.CMD_VALID & cmd_ready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clk      (PCLK),
    .rst      (PRESET),
    .clear    (state != ACCESS),
    .count_en ((state == ACCESS) & ~bus.PREADY),
    .expired  (expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        pwrite_q <= bus.CMD_WRITE;
        paddr_q  <= bus.CMD_ADDR;
        pwdata_q <= bus.CMD_WDATA;
      end
      rsp_valid_q <= complete | abort;
      if (complete) begin
        rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
        rsp_err_q     <= bus.PSLVERR;
        rsp_timeout_q <= 1'b0;
      end else if (abort) begin
        rsp_rdata_q   <= '0;
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  assign bus.CMD_READY   = cmd_ready;
  assign bus.PSELx       = (state != IDLE);
  assign bus.PENABLE     = (state == ACCESS);
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.RSP_VALID   = rsp_valid_q;
  assign bus.RSP_RDATA   = rsp_rdata_q;
  assign bus.RSP_ERR     = rsp_err_q;
  assign bus.RSP_TIMEOUT = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_apb_master : table, hand-written and random checks of apb_master.  Rev 1.0
// ------------------------------------------------------------------------
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (8)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_tmo;
    int          e_lat;
    int          e_acc;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input int w, input logic [31:0] p, input logic se,
                              input logic [31:0] er, input logic ee, input logic et,
                              input int el, input int ea);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.waits = w; v.prdata = p; v.slverr = se;
    v.e_rdata = er; v.e_err = ee; v.e_tmo = et; v.e_lat = el; v.e_acc = ea;
    return v;
  endfunction

  // Reference: a completer that stalls `waits` cycles either answers or is cut off at TO ACCESS cycles
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic tmo = (TO != 0) && (v.waits >= TO);
    r.e_tmo   = tmo;
    r.e_err   = tmo | v.slverr;
    r.e_rdata = (tmo || v.wr) ? 32'h0 : v.prdata;
    r.e_lat   = tmo ? TO + 2 : v.waits + 3;
    r.e_acc   = tmo ? TO : v.waits + 1;
    return r;
  endfunction

  task automatic idle_bus();
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'($urandom_range(0, 1));
    bus.PRDATA  = $urandom;
  endtask

  task automatic run_txn(input vec_t v);
    int acc = 0;
    int lat = 0;
    int path_bad = 0;
    int rdy_bad = 0;
    logic got = 1'b0;
    logic psel_at_rsp = 1'b1;
    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.CMD_READY), 32'd1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = v.wr;
    bus.CMD_ADDR  = v.addr;
    bus.CMD_WDATA = v.wdata;
    @(posedge clk);
    #1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_ADDR  = $urandom;
    bus.CMD_WDATA = $urandom;
    for (int n = 1; n <= TO + 40 && !got; n++) begin
      @(negedge clk);
      if (bus.RSP_VALID) begin
        got = 1'b1;
        lat = n;
        psel_at_rsp = bus.PSELx;
        idle_bus();
      end else if (bus.PSELx && bus.PENABLE) begin
        acc++;
        if (bus.PADDR !== v.addr || bus.PWRITE !== v.wr || bus.PWDATA !== v.wdata) path_bad++;
        if (acc - 1 == v.waits) begin
          bus.PREADY = 1'b1; bus.PSLVERR = v.slverr; bus.PRDATA = v.prdata;
        end else begin
          bus.PREADY = 1'b0; bus.PSLVERR = 1'b1; bus.PRDATA = $urandom;
        end
        #1;
        if (bus.CMD_READY !== bus.PREADY) rdy_bad++;
      end else begin
        if (bus.PSELx && bus.CMD_READY !== 1'b0) rdy_bad++;
        idle_bus();
      end
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(v.e_lat));
    check("access_cycles", 32'(acc), 32'(v.e_acc));
    check("bus_stable", 32'(path_bad), 32'd0);
    check("cmd_ready_busy", 32'(rdy_bad), 32'd0);
    check("psel_after", 32'(psel_at_rsp), 32'd0);
    check("rsp_rdata", bus.RSP_RDATA, v.e_rdata);
    check("rsp_err", 32'(bus.RSP_ERR), 32'(v.e_err));
    check("rsp_timeout", 32'(bus.RSP_TIMEOUT), 32'(v.e_tmo));
    check("paddr_hold", bus.PADDR, v.addr);
    @(negedge clk);
    check("rsp_pulse", 32'(bus.RSP_VALID), 32'd0);
    check("rdata_hold", bus.RSP_RDATA, v.e_rdata);
  endtask

  vec_t tbl[7];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    vec_t v;
    tbl[0] = mk(1'b1, APB_ADDR_CONFIG,  32'h0000_1A2B, 0,  32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 3,  1);
    tbl[1] = mk(1'b0, APB_ADDR_RX,      32'h0,         3,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 6,  4);
    tbl[2] = mk(1'b1, APB_ADDR_TX,      32'h0000_55AA, 2,  32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 5,  3);
    tbl[3] = mk(1'b0, APB_ADDR_TIMEOUT, 32'h0,         0,  32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 3,  1);
    tbl[4] = mk(1'b0, APB_ADDR_RX,      32'h0,         99, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 1'b1, 18, 16);
    tbl[5] = mk(1'b1, APB_ADDR_CONFIG,  32'hCAFE_0001, 15, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 18, 16);
    tbl[6] = mk(1'b0, APB_ADDR_TX,      32'h0,         1,  32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F, 1'b0, 1'b0, 4,  2);

    rst = 1'b1;
    bus.CMD_VALID = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = '0; bus.CMD_WDATA = '0;
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_TIMEOUT},
          32'd0);
    check("reset_paddr", bus.PADDR | bus.PWDATA | bus.RSP_RDATA, 32'd0);
    check("reset_cmd_ready", 32'(bus.CMD_READY), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Reset while the completer is stalling
    @(negedge clk);
    bus.CMD_VALID = 1'b1; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = APB_ADDR_RX; bus.CMD_WDATA = 32'h7777_0000;
    @(posedge clk);
    #1 bus.CMD_VALID = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_wait", 32'(bus.PENABLE), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_bus", {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.RSP_VALID, bus.RSP_ERR, bus.RSP_TIMEOUT},
          32'd0);
    check("midrst_data", bus.PADDR | bus.PWDATA | bus.RSP_RDATA, 32'd0);
    rst = 1'b0;
    check("midrst_ready", 32'(bus.CMD_READY), 32'd1);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.RSP_VALID || bus.PSELx) bad++;
    end
    check("midrst_no_rsp", 32'(bad), 32'd0);

    // Back-to-back: second command accepted in the first transfer's completion cycle
    @(negedge clk);
    bus.CMD_VALID = 1'b1; bus.CMD_WRITE = 1'b1; bus.CMD_ADDR = APB_ADDR_TX; bus.CMD_WDATA = 32'h1111_1111;
    bus.PREADY = 1'b0;
    @(negedge clk);
    check("b2b_setup1", {bus.PSELx, bus.PENABLE, bus.CMD_READY}, 32'b100);
    bus.CMD_ADDR = APB_ADDR_TIMEOUT; bus.CMD_WDATA = 32'h2222_2222;
    @(negedge clk);
    check("b2b_access1", {bus.PSELx, bus.PENABLE}, 32'b11);
    check("b2b_paddr1", bus.PADDR, APB_ADDR_TX);
    bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
    #1 check("b2b_ready_comb", 32'(bus.CMD_READY), 32'd1);
    @(negedge clk);
    check("b2b_setup2", {bus.RSP_VALID, bus.PSELx, bus.PENABLE}, 32'b110);
    check("b2b_paddr2", bus.PADDR, APB_ADDR_TIMEOUT);
    check("b2b_pwdata2", bus.PWDATA, 32'h2222_2222);
    bus.CMD_VALID = 1'b0; bus.PREADY = 1'b0;
    @(negedge clk);
    check("b2b_access2", {bus.RSP_VALID, bus.PSELx, bus.PENABLE}, 32'b011);
    bus.PREADY = 1'b1;
    @(negedge clk);
    check("b2b_rsp2", {bus.RSP_VALID, bus.PSELx, bus.RSP_ERR}, 32'b100);
    bus.PREADY = 1'b0;

    for (int i = 0; i < 30; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v.addr = APB_ADDR_TX;
        1:       v.addr = APB_ADDR_RX;
        2:       v.addr = APB_ADDR_CONFIG;
        default: v.addr = APB_ADDR_TIMEOUT;
      endcase
      v.wdata  = $urandom;
      v.waits  = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      v.prdata = $urandom;
      v.slverr = 1'($urandom_range(0, 1));
      run_txn(model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
